// File: rtl/tm1638_bus_scheduler.sv
// Bus scheduler for a TM1638 shield shared by a display refresher and a key-scan reader.
// Raises timed/host requests, arbitrates round-robin, guards each transaction with a watchdog, debounces keys.
module tm1638_bus_scheduler #(
    parameter int CLOCK_FREQ_MHz   = 12,
    parameter int REFRESH_US       = 20000,
    parameter int KEYSCAN_US       = 10000,
    parameter int DEBOUNCE_SAMPLES = 3,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_dirty,
    input  logic       i_disp_idle,
    output logic       o_disp_en,
    input  logic       i_key_idle,
    output logic       o_key_en,
    input  logic       i_key_valid,
    input  logic [7:0] i_key_state,
    output logic       o_sel,
    output logic [7:0] o_keys,
    output logic       o_key_event,
    output logic       o_busy,
    output logic       o_fault
);

    // state   | meaning
    // S_IDLE  | waiting for a request with both engines idle
    // S_START | one-cycle start pulse to the selected engine
    // S_GUARD | ignore idle while the engine registers its start
    // S_WAIT  | wait for selected engine idle, watchdog running
    typedef enum logic [1:0] {S_IDLE, S_START, S_GUARD, S_WAIT} state_t;

    localparam int TR_N = CLOCK_FREQ_MHz * REFRESH_US;
    localparam int TK_N = CLOCK_FREQ_MHz * KEYSCAN_US;
    localparam int TR_W = (TR_N > 1) ? $clog2(TR_N) : 1;
    localparam int TK_W = (TK_N > 1) ? $clog2(TK_N) : 1;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TR_W-1:0] TR_TC = TR_W'(TR_N - 1);
    localparam logic [TK_W-1:0] TK_TC = TK_W'(TK_N - 1);
    localparam logic [WD_W-1:0] WD_TC = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      DB_N  = 4'(DEBOUNCE_SAMPLES);

    state_t          st_q, st_d;
    logic            sel_q, sel_d;
    logic            last_q, last_d;
    logic            disp_pend_q, disp_pend_d;
    logic            key_pend_q, key_pend_d;
    logic            fault_q, fault_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [TR_W-1:0] tmr_r_q, tmr_r_d;
    logic [TK_W-1:0] tmr_k_q, tmr_k_d;
    logic [7:0]      cand_q, cand_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      keys_q, keys_d;
    logic            key_event_q, key_event_d;

    logic r_exp, k_exp, start_disp, start_key, sel_idle, kv_ok;

    always_comb begin
        st_d        = st_q;
        sel_d       = sel_q;
        last_d      = last_q;
        fault_d     = fault_q;
        wd_d        = wd_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        keys_d      = keys_q;
        key_event_d = 1'b0;

        r_exp   = (tmr_r_q == TR_TC);
        k_exp   = (tmr_k_q == TK_TC);
        tmr_r_d = r_exp ? '0 : tmr_r_q + 1'b1;
        tmr_k_d = k_exp ? '0 : tmr_k_q + 1'b1;

        start_disp = (st_q == S_START) && !sel_q;
        start_key  = (st_q == S_START) &&  sel_q;
        // A set in the same cycle as the clear wins, so a mid-refresh write is not lost.
        disp_pend_d = (disp_pend_q && !start_disp) || i_dirty || r_exp;
        key_pend_d  = (key_pend_q  && !start_key)  || k_exp;

        sel_idle = sel_q ? i_key_idle : i_disp_idle;

        case (st_q)
            S_IDLE: begin
                if (i_disp_idle && i_key_idle && (disp_pend_q || key_pend_q)) begin
                    if (disp_pend_q && key_pend_q) sel_d = ~last_q;
                    else                           sel_d = key_pend_q;
                    st_d = S_START;
                end
            end
            S_START: begin
                last_d = sel_q;
                st_d   = S_GUARD;
            end
            S_GUARD: begin
                wd_d = '0;
                st_d = S_WAIT;
            end
            S_WAIT: begin
                if (sel_idle) begin
                    st_d = S_IDLE;
                end else if (wd_q == WD_TC) begin
                    fault_d = 1'b1;
                    st_d    = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: st_d = S_IDLE;
        endcase

        kv_ok = i_key_valid && sel_q && ((st_q == S_GUARD) || (st_q == S_WAIT));
        if (kv_ok) begin
            if (i_key_state == cand_q) begin
                if (cnt_q != DB_N) cnt_d = cnt_q + 1'b1;
            end else begin
                cand_d = i_key_state;
                cnt_d  = 4'd1;
            end
            if ((cnt_d == DB_N) && (cand_d != keys_q)) begin
                keys_d      = cand_d;
                key_event_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_q        <= S_IDLE;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            disp_pend_q <= 1'b1;
            key_pend_q  <= 1'b0;
            fault_q     <= 1'b0;
            wd_q        <= '0;
            tmr_r_q     <= '0;
            tmr_k_q     <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            keys_q      <= '0;
            key_event_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            disp_pend_q <= disp_pend_d;
            key_pend_q  <= key_pend_d;
            fault_q     <= fault_d;
            wd_q        <= wd_d;
            tmr_r_q     <= tmr_r_d;
            tmr_k_q     <= tmr_k_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            keys_q      <= keys_d;
            key_event_q <= key_event_d;
        end
    end

    assign o_disp_en   = start_disp;
    assign o_key_en    = start_key;
    assign o_sel       = sel_q;
    assign o_keys      = keys_q;
    assign o_key_event = key_event_q;
    assign o_busy      = (st_q != S_IDLE);
    assign o_fault     = fault_q;

endmodule

// File: tb/tb_tm1638_bus_scheduler.sv
// Directed bench for tm1638_bus_scheduler with simple display/key engine models.
module tb_tm1638_bus_scheduler;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_dirty = 1'b0;
    logic       i_disp_idle;
    logic       o_disp_en;
    logic       i_key_idle;
    logic       o_key_en;
    logic       i_key_valid;
    logic [7:0] i_key_state;
    logic       o_sel;
    logic [7:0] o_keys;
    logic       o_key_event;
    logic       o_busy;
    logic       o_fault;

    tm1638_bus_scheduler #(
        .CLOCK_FREQ_MHz(1),
        .REFRESH_US(1000),
        .KEYSCAN_US(50),
        .DEBOUNCE_SAMPLES(3),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_dirty(i_dirty),
        .i_disp_idle(i_disp_idle),
        .o_disp_en(o_disp_en),
        .i_key_idle(i_key_idle),
        .o_key_en(o_key_en),
        .i_key_valid(i_key_valid),
        .i_key_state(i_key_state),
        .o_sel(o_sel),
        .o_keys(o_keys),
        .o_key_event(o_key_event),
        .o_busy(o_busy),
        .o_fault(o_fault)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Engine models: idle drops the edge after a start, key engine strobes its byte mid-transaction.
    int         disp_cnt = 0;
    int         key_cnt = 0;
    logic       disp_hold = 1'b0;
    logic       key_force = 1'b0;
    logic [7:0] key_data = 8'h00;

    always @(posedge i_clk) begin
        if (o_disp_en) disp_cnt <= 5;
        else if (disp_cnt != 0) disp_cnt <= disp_cnt - 1;
        if (o_key_en) key_cnt <= 4;
        else if (key_cnt != 0) key_cnt <= key_cnt - 1;
    end

    assign i_disp_idle = (disp_cnt == 0) && !disp_hold;
    assign i_key_idle  = (key_cnt == 0);
    assign i_key_valid = (key_cnt == 2) || key_force;
    assign i_key_state = key_data;

    int edge_n;
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    int   disp_pulses = 0, disp_edge = 0;
    logic disp_sel = 1'b1;
    int   key_pulses = 0, key_edge = 0;
    int   ev_cnt = 0, ev_edge = 0;
    int   fault_edge = 0;

    always @(negedge i_clk) begin
        if (o_disp_en) begin
            disp_pulses <= disp_pulses + 1;
            disp_edge   <= edge_n;
            disp_sel    <= o_sel;
        end
        if (o_key_en) begin
            key_pulses <= key_pulses + 1;
            key_edge   <= edge_n;
        end
        if (o_key_event) begin
            ev_cnt  <= ev_cnt + 1;
            ev_edge <= edge_n;
        end
        if (o_fault && fault_edge == 0) fault_edge <= edge_n;
    end

    task automatic to_edge(input int n);
        for (int i = 0; i < 5000 && edge_n != n; i++) @(negedge i_clk);
        #1;
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    int d0, e0, k0;

    initial begin
        // Reset and first refresh
        repeat (3) @(negedge i_clk);
        #1;
        check_eq("reset_outputs", {18'd0, o_disp_en, o_key_en, o_sel, o_busy, o_fault, o_key_event, o_keys}, 32'd0);
        d0 = disp_pulses;
        k0 = key_pulses;
        i_rst = 1'b0;
        to_edge(45);
        check_eq("first_refresh_edge", disp_edge, 1);
        check_eq("first_refresh_sel", disp_sel, 0);
        check_eq("quiet_until_keyscan", {disp_pulses - d0, key_pulses - k0}, {32'd1, 32'd0});
        to_edge(60);
        check_eq("first_keypoll_edge", key_edge, 51);
        check_eq("keypoll_sel", o_sel, 1);
        to_edge(69);
        i_dirty = 1'b1;
        to_edge(70);
        i_dirty = 1'b0;
        to_edge(90);
        check_eq("dirty_latency", disp_edge, 71);

        // Dirty and keyscan expiry together, last served was display
        to_edge(99);
        i_dirty = 1'b1;
        to_edge(100);
        i_dirty = 1'b0;
        to_edge(120);
        check_eq("rr_key_first", key_edge, 101);
        check_eq("rr_disp_after", disp_edge, 108);
        check_eq("rr_disp_sel", disp_sel, 0);

        // Debounce
        key_data = 8'h05;
        pulse_reset();
        e0 = ev_cnt;
        to_edge(130);
        check_eq("keys_two_polls", o_keys, 8'h00);
        to_edge(170);
        check_eq("keys_accepted", o_keys, 8'h05);
        check_eq("one_event", ev_cnt - e0, 1);
        check_eq("event_edge", ev_edge, 155);
        to_edge(225);
        key_data = 8'h04;
        to_edge(275);
        key_data = 8'h05;
        to_edge(320);
        check_eq("keys_glitch_held", o_keys, 8'h05);
        check_eq("no_glitch_event", ev_cnt - e0, 1);
        to_edge(325);
        key_data  = 8'h33;
        key_force = 1'b1;
        to_edge(328);
        key_force = 1'b0;
        key_data  = 8'h05;
        to_edge(340);
        check_eq("valid_ignored_idle", o_keys, 8'h05);
        check_eq("no_event_idle", ev_cnt - e0, 1);

        // Dirty during a refresh
        pulse_reset();
        d0 = disp_pulses;
        to_edge(1);
        i_dirty = 1'b1;
        to_edge(3);
        i_dirty = 1'b0;
        to_edge(45);
        check_eq("dirty_mid_refresh_count", disp_pulses - d0, 2);
        check_eq("dirty_mid_refresh_edge", disp_edge, 9);

        // Watchdog
        to_edge(60);
        pulse_reset();
        to_edge(1);
        disp_hold = 1'b1;
        to_edge(20);
        check_eq("wd_back_idle", o_busy, 0);
        disp_hold = 1'b0;
        to_edge(40);
        check_eq("wd_fault_edge", fault_edge, 19);
        to_edge(60);
        check_eq("poll_after_fault", key_edge, 51);
        check_eq("fault_sticky", o_fault, 1);

        // Reset during a key transaction in S_WAIT
        to_edge(104);
        check_eq("busy_before_reset", o_busy, 1);
        i_rst = 1'b1;
        #1;
        check_eq("async_reset_outputs", {18'd0, o_disp_en, o_key_en, o_sel, o_busy, o_fault, o_key_event, o_keys}, 32'd0);
        @(negedge i_clk);
        #1;
        i_rst = 1'b0;
        to_edge(1);
        check_eq("wait_key_idle", o_busy, 0);
        to_edge(10);
        check_eq("refresh_after_reset", disp_edge, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tm1638_bus_scheduler.md
# tm1638_bus_scheduler

Sequences access to a single TM1638 shield bus shared by two engines: the memory-mapped display refresher and the key-scan reader. It raises refresh requests from host writes and a periodic timer, raises key polls from a second timer, and arbitrates between them round-robin. It issues one-cycle start pulses, waits for each engine to finish under a watchdog, steers the pin mux, and debounces the returned button byte.

## Interface
- CLOCK_FREQ_MHz, 12, clock frequency; cycles per microsecond
- REFRESH_US, 20000, periodic display refresh interval
- KEYSCAN_US, 10000, key poll interval
- DEBOUNCE_SAMPLES, 3, consecutive identical key reads required to accept a value (1..15)
- TIMEOUT_CYCLES, 65535, watchdog limit while waiting for an engine
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_dirty  in  1  host wrote display memory; request refresh
- i_disp_idle  in  1  display engine idle
- o_disp_en  out  1  one-cycle display refresh start
- i_key_idle  in  1  key engine idle
- o_key_en  out  1  one-cycle key read start
- i_key_valid  in  1  key engine result strobe
- i_key_state  in  8  raw button byte (1 = pressed)
- o_sel  out  1  pin mux select: 0 = display engine, 1 = key engine
- o_keys  out  8  debounced button state
- o_key_event  out  1  one-cycle pulse when o_keys changes
- o_busy  out  1  a transaction is in progress
- o_fault  out  1  sticky watchdog timeout flag

## Operation
- Reset values: all outputs 0; both timers 0; disp_pend=1, so the first action after reset is a display refresh; key_pend=0; last_served=key; debounce count 0.
- Timers: free-running cycle counters with terminal counts CLOCK_FREQ_MHz*REFRESH_US-1 and CLOCK_FREQ_MHz*KEYSCAN_US-1. At terminal count the counter wraps to 0 and sets its pending flag.
- disp_pend is set by i_dirty or refresh timer expiry. key_pend is set by keyscan timer expiry.
- A pending flag is cleared when its start pulse is issued. If a set and a clear occur in the same cycle, the set wins. An i_dirty during a refresh therefore causes one further refresh.
- States: S_IDLE, S_START, S_GUARD, S_WAIT.
- S_IDLE:
  - Requires i_disp_idle and i_key_idle both high before granting.
  - With one request pending, grant it. With both pending, grant the one not equal to last_served.
  - On grant: set o_sel, go to S_START.
- S_START:
  - Assert the selected en for one cycle; clear the matching pending flag; set last_served; o_busy=1.
  - Go to S_GUARD.
- S_GUARD: one cycle in which idle is ignored, covering the engine's registered idle. Then go to S_WAIT.
- S_WAIT:
  - Leave when the selected engine's idle=1, returning to S_IDLE with o_busy=0.
  - The watchdog counts cycles spent in S_WAIT. On reaching TIMEOUT_CYCLES, set o_fault and return to S_IDLE.
- o_sel changes only on the S_IDLE→S_START transition and is held until the next grant.
- Debounce:
  - i_key_valid is honoured only in S_GUARD or S_WAIT with o_sel=1; it is ignored otherwise.
  - If i_key_state equals the candidate, the count increments, saturating at DEBOUNCE_SAMPLES. Otherwise the candidate is set to i_key_state and the count to 1.
  - When the count reaches DEBOUNCE_SAMPLES and the candidate differs from o_keys: o_keys takes the candidate and o_key_event pulses for one cycle.
- Reset mid-transaction: everything returns to reset values immediately. The engines are not aborted; the post-reset refresh waits in S_IDLE until both idles are high.

## Timing
- i_dirty sampled at edge k, with S_IDLE and engines idle: disp_pend=1 after edge k, o_disp_en high in the cycle after edge k+1.
  - Latency is 2 cycles.
- Minimum transaction is 4 cycles (START, GUARD, WAIT with idle already high, IDLE), so back-to-back grants are at least 4 cycles apart.
- o_key_event is coincident with the o_keys update, 1 cycle after the accepting i_key_valid.
- Timer period is exact, with no drift: expiry every CLOCK_FREQ_MHz*X_US cycles regardless of grants.

## Test plan
- Reset release with idle engines: o_disp_en pulses within 2 cycles, o_sel=0, then no activity until the first keyscan expiry.
- i_dirty and keyscan expiry in the same cycle, last_served=display: o_key_en is issued first, then o_disp_en once i_key_idle returns.
- i_key_state=0x05 returned on 3 successive polls: o_keys=0x05 with a single o_key_event. Then 0x05, 0x04, 0x05: no change.
- i_dirty pulsed during a refresh: exactly one additional o_disp_en follows completion.
- i_disp_idle stuck low after a grant: o_fault=1 after TIMEOUT_CYCLES (set 16 in the bench), the FSM returns to S_IDLE, and a subsequent key poll is granted normally.
- i_rst asserted during S_WAIT: outputs are 0 asynchronously; after release, a refresh is issued once both idles are high.
